and_gate_stim_gen: RTL and testbench

- Self-checking stimulus generator for the AND-gate bench; the driving counterpart of the bench's unknown-value input monitor.
- Sweeps every combination of the `a` and `b` buses into the DUT.
- Compares the DUT output `y` against a delay-matched `a & b` reference, counts mismatches and reports pass/fail with a one-cycle done pulse.
- Fully synthesizable, so it can also run as an on-chip BIST.

---
 rtl/and_gate_stim_gen_if.sv | 50 +++++
 rtl/and_gate_stim_gen.sv | 213 +++++++++++++++++++++
 tb/tb_and_gate_stim_gen.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/and_gate_stim_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : and_gate_stim_gen_if
// Desc     : Control, stimulus and result signals between the AND-gate
//            stimulus generator (master) and the bench/DUT side (slave).
//            AND_STIM_FIRST_FAIL_EN adds the first-failure capture signals.
// Revision : 1.0 - initial release
// ============================================================================
interface and_gate_stim_gen_if #(
   parameter int WIDTH = 1
);
   logic             start;
   logic             abort;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             stim_valid;
   logic [WIDTH-1:0] y;
   logic             busy;
   logic             done;
   logic             pass;
   logic [15:0]      err_count;
`ifdef AND_STIM_FIRST_FAIL_EN
   logic [WIDTH-1:0] fail_a;
   logic [WIDTH-1:0] fail_b;
   logic             fail_valid;

   modport master (
      input  start, abort, y,
      output a, b, stim_valid, busy, done, pass, err_count,
      output fail_a, fail_b, fail_valid
   );

   modport slave (
      output start, abort, y,
      input  a, b, stim_valid, busy, done, pass, err_count,
      input  fail_a, fail_b, fail_valid
   );
`else
   modport master (
      input  start, abort, y,
      output a, b, stim_valid, busy, done, pass, err_count
   );

   modport slave (
      output start, abort, y,
      input  a, b, stim_valid, busy, done, pass, err_count
   );
`endif
endinterface
`default_nettype wire

// File: rtl/and_gate_stim_gen.sv
`default_nettype none
// ============================================================================
// Module   : and_gate_stim_gen
// Desc     : Exhaustive a/b sweep into an AND-gate DUT with a delay-matched
//            a & b reference check, saturating mismatch count and done pulse.
//            Optional macro AND_STIM_FIRST_FAIL_EN: first-failure capture.
// Revision : 1.0 - initial release
// ============================================================================
module and_gate_stim_gen #(
   parameter int WIDTH       = 1,
   parameter int DUT_LATENCY = 0
) (
   input  wire logic           clk,
   input  wire logic           reset,
   and_gate_stim_gen_if.master bus
);

   localparam int         c_CNT_W      = 2 * WIDTH;
   localparam logic [2:0] c_LAST_DRAIN = 3'((DUT_LATENCY > 0) ? DUT_LATENCY - 1 : 0);

   generate
      if (WIDTH < 1 || WIDTH > 8) begin : g_bad_width
         $error("and_gate_stim_gen: WIDTH=%0d is outside 1..8", WIDTH);
      end
      if (DUT_LATENCY < 0 || DUT_LATENCY > 7) begin : g_bad_latency
         $error("and_gate_stim_gen: DUT_LATENCY=%0d is outside 0..7", DUT_LATENCY);
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t             r_state;
   logic [c_CNT_W-1:0] r_cnt;
   logic [2:0]         r_drain;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic               r_stim_valid;
   logic               r_busy;
   logic               r_done;
   logic               r_pass;
   logic [15:0]        r_err;

   logic               w_flush;
   logic               w_dvalid;
   logic [WIDTH-1:0]   w_da;
   logic [WIDTH-1:0]   w_db;
   logic               w_mismatch;
   logic               w_count;
   logic [15:0]        w_err_next;

   // Abort discards whatever is still in flight, including this cycle's compare.
   assign w_flush = bus.abort && (r_state == S_DRIVE || r_state == S_DRAIN);

   generate
      if (DUT_LATENCY == 0) begin : g_no_pipe
         assign w_dvalid = r_stim_valid;
         assign w_da     = r_a;
         assign w_db     = r_b;
      end else begin : g_pipe
         logic [DUT_LATENCY-1:0] r_pv;
         logic [WIDTH-1:0]       r_pa [DUT_LATENCY];
         logic [WIDTH-1:0]       r_pb [DUT_LATENCY];

         always_ff @(posedge clk) begin
            if (!reset || w_flush) begin
               r_pv <= '0;
               for (int i = 0; i < DUT_LATENCY; i++) begin
                  r_pa[i] <= '0;
                  r_pb[i] <= '0;
               end
            end else begin
               r_pv[0] <= r_stim_valid;
               r_pa[0] <= r_a;
               r_pb[0] <= r_b;
               for (int i = 1; i < DUT_LATENCY; i++) begin
                  r_pv[i] <= r_pv[i-1];
                  r_pa[i] <= r_pa[i-1];
                  r_pb[i] <= r_pb[i-1];
               end
            end
         end

         assign w_dvalid = r_pv[DUT_LATENCY-1];
         assign w_da     = r_pa[DUT_LATENCY-1];
         assign w_db     = r_pb[DUT_LATENCY-1];
      end
   endgenerate

   // Case inequality so an unknown y from the DUT scores as a failure.
   assign w_mismatch = w_dvalid && (bus.y !== (w_da & w_db));
   assign w_count    = w_mismatch && !w_flush;
   assign w_err_next = (w_count && r_err != 16'hFFFF) ? r_err + 16'd1 : r_err;

`ifdef AND_STIM_FIRST_FAIL_EN
   logic [WIDTH-1:0] r_fail_a;
   logic [WIDTH-1:0] r_fail_b;
   logic             r_fail_valid;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_drain      <= '0;
         r_a          <= '0;
         r_b          <= '0;
         r_stim_valid <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_err        <= '0;
`ifdef AND_STIM_FIRST_FAIL_EN
         r_fail_a     <= '0;
         r_fail_b     <= '0;
         r_fail_valid <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         r_err  <= w_err_next;
`ifdef AND_STIM_FIRST_FAIL_EN
         if (w_count && !r_fail_valid) begin
            r_fail_a     <= w_da;
            r_fail_b     <= w_db;
            r_fail_valid <= 1'b1;
         end
`endif
         case (r_state)
            S_IDLE: begin
               if (!bus.abort && bus.start) begin
                  r_state      <= S_DRIVE;
                  r_cnt        <= '0;
                  r_a          <= '0;
                  r_b          <= '0;
                  r_stim_valid <= 1'b1;
                  r_busy       <= 1'b1;
                  r_pass       <= 1'b0;
                  r_err        <= '0;
`ifdef AND_STIM_FIRST_FAIL_EN
                  r_fail_a     <= '0;
                  r_fail_b     <= '0;
                  r_fail_valid <= 1'b0;
`endif
               end
            end
            S_DRIVE: begin
               if (bus.abort) begin
                  r_state      <= S_IDLE;
                  r_cnt        <= '0;
                  r_stim_valid <= 1'b0;
                  r_busy       <= 1'b0;
                  r_pass       <= 1'b0;
               end else if (r_cnt == {c_CNT_W{1'b1}}) begin
                  // a/b keep the last vector while the counter wraps.
                  r_cnt        <= '0;
                  r_stim_valid <= 1'b0;
                  if (DUT_LATENCY == 0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                     r_pass  <= (w_err_next == 16'd0);
                  end else begin
                     r_state <= S_DRAIN;
                     r_drain <= '0;
                  end
               end else begin
                  r_cnt        <= r_cnt + 1'b1;
                  {r_b, r_a}   <= r_cnt + 1'b1;
               end
            end
            S_DRAIN: begin
               if (bus.abort) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_pass  <= 1'b0;
               end else if (r_drain == c_LAST_DRAIN) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_pass  <= (w_err_next == 16'd0);
               end else begin
                  r_drain <= r_drain + 3'd1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.a          = r_a;
   assign bus.b          = r_b;
   assign bus.stim_valid = r_stim_valid;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.pass       = r_pass;
   assign bus.err_count  = r_err;
`ifdef AND_STIM_FIRST_FAIL_EN
   assign bus.fail_a     = r_fail_a;
   assign bus.fail_b     = r_fail_b;
   assign bus.fail_valid = r_fail_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_and_gate_stim_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_and_gate_stim_gen
// Desc     : Randomized bench for and_gate_stim_gen (WIDTH=2, DUT_LATENCY=2)
//            with a sweep-timeline reference model and a faulty-DUT emulator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_and_gate_stim_gen;

   localparam int W = 2;
   localparam int L = 2;
   localparam int N = 1 << (2 * W);
   localparam int T_DONE = N + L + 1;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   bit   chk_en = 1'b0;
   int   n_cmp  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   and_gate_stim_gen_if #(.WIDTH(W)) bus ();

   and_gate_stim_gen #(.WIDTH(W), .DUT_LATENCY(L)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Emulated DUT: L-cycle pipeline followed by a selectable (possibly broken) gate.
   int             mode = 0;
   logic [W-1:0]   mask [N];
   logic [W-1:0]   pa [L];
   logic [W-1:0]   pb [L];

   always @(posedge clk) begin
      pa[0] <= bus.a;
      pb[0] <= bus.b;
      for (int i = 1; i < L; i++) begin
         pa[i] <= pa[i-1];
         pb[i] <= pb[i-1];
      end
   end

   function automatic logic [W-1:0] gate_out(int md, logic [W-1:0] x, logic [W-1:0] z);
      case (md)
         0:       return x & z;
         1:       return x | z;
         2:       return '0;
         3:       return (x & z) ^ mask[{z, x}];
         default: return '1;
      endcase
   endfunction

   assign bus.y = gate_out(mode, pa[L-1], pb[L-1]);

   // Reference: which vectors the emulated DUT gets wrong, and the sweep timeline.
   bit bad [N];
   int total_bad;

   function automatic int cnt_bad(int upto);
      int c = 0;
      for (int v = 0; v < N; v++)
         if (v < upto && bad[v]) c++;
      return (c > 65535) ? 65535 : c;
   endfunction

   task automatic set_fault(input int md);
      logic [2*W-1:0] vv;
      mode = md;
      for (int v = 0; v < N; v++) mask[v] = W'($urandom);
      total_bad = 0;
      for (int v = 0; v < N; v++) begin
         vv     = (2*W)'(v);
         bad[v] = (gate_out(md, vv[W-1:0], vv[2*W-1:W]) !== (vv[W-1:0] & vv[2*W-1:W]));
         if (bad[v]) total_bad++;
      end
   endtask

   // m_k = cycle number within the current sweep (0 = idle).
   int m_k = 0;
   int m_err = 0;
   bit m_pass = 1'b0;
   bit m_ab_zero = 1'b1;

   always @(posedge clk) begin
      if (!reset) begin
         m_k = 0; m_err = 0; m_pass = 1'b0; m_ab_zero = 1'b1;
      end else if (m_k == 0) begin
         if (bus.start && !bus.abort) begin
            m_k = 1; m_pass = 1'b0; m_ab_zero = 1'b0;
         end
      end else if (m_k < T_DONE && bus.abort) begin
         m_err = cnt_bad(m_k - L - 1);
         m_k = 0; m_pass = 1'b0;
      end else if (m_k == T_DONE) begin
         m_err = cnt_bad(N);
         m_pass = (cnt_bad(N) == 0);
         m_k = 0;
      end else begin
         m_k++;
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         if (m_k == 0) begin
            check("idle_busy",  32'(bus.busy), 0);
            check("idle_done",  32'(bus.done), 0);
            check("idle_valid", 32'(bus.stim_valid), 0);
            check("idle_pass",  32'(bus.pass), 32'(m_pass));
            check("idle_err",   32'(bus.err_count), 32'(m_err));
            if (m_ab_zero) begin
               check("idle_a", 32'(bus.a), 0);
               check("idle_b", 32'(bus.b), 0);
            end
         end else begin
            check("busy",  32'(bus.busy), 1);
            check("done",  32'(bus.done), 32'(m_k == T_DONE));
            check("valid", 32'(bus.stim_valid), 32'(m_k <= N));
            if (m_k <= N) begin
               check("a", 32'(bus.a), 32'((m_k - 1) % (1 << W)));
               check("b", 32'(bus.b), 32'((m_k - 1) >> W));
            end
            if (m_k == T_DONE) begin
               check("err_final", 32'(bus.err_count), 32'(cnt_bad(N)));
               check("pass_final", 32'(bus.pass), 32'(total_bad == 0));
            end else begin
               check("err_run",  32'(bus.err_count), 32'(cnt_bad(m_k - L - 1)));
               check("pass_run", 32'(bus.pass), 0);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Starts a sweep; optionally aborts at cycle abort_at or sprays start while busy.
   task automatic sweep(input int md, input int abort_at, input bit spam,
                        output int cyc, output bit got_done);
      set_fault(md);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      cyc = 1;
      got_done = 1'b0;
      while (cyc < 60) begin
         if (bus.done) begin
            got_done = 1'b1;
            break;
         end
         if (cyc == abort_at) begin
            bus.abort = 1'b1;
            step();
            bus.abort = 1'b0;
            cyc++;
            break;
         end
         if (spam) bus.start = 1'($urandom_range(0, 1));
         step();
         bus.start = 1'b0;
         cyc++;
      end
      bus.start = 1'b0;
   endtask

   int cyc;
   bit got;
   bit seen;

   initial begin
      bus.start = 1'b0;
      bus.abort = 1'b0;
      set_fault(0);
      step();
      chk_en = 1'b1;
      step();
      reset = 1'b1;
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_err",  32'(bus.err_count), 0);
      step();

      // Correct pipelined AND: done at cycle N+L+1 = 19, pass.
      sweep(0, 0, 1'b0, cyc, got);
      check("and_done_cycle", 32'(cyc), 19);
      check("and_pass", 32'(bus.pass), 1);
      check("and_err",  32'(bus.err_count), 0);
      repeat (2) step();

      // OR substituted: mismatches where a != b.
      sweep(1, 0, 1'b0, cyc, got);
      check("or_err",  32'(bus.err_count), 12);
      check("or_pass", 32'(bus.pass), 0);
      step();

      // Stuck-at-0: mismatches where a & b != 0.
      sweep(2, 0, 1'b0, cyc, got);
      check("stuck0_err", 32'(bus.err_count), 7);
      step();

      // Abort at cycle 3, then a full restart.
      sweep(0, 3, 1'b0, cyc, got);
      check("abort_no_done", 32'(got), 0);
      check("abort_busy",    32'(bus.busy), 0);
      step();
      sweep(0, 0, 1'b0, cyc, got);
      check("restart_pass", 32'(bus.pass), 1);
      check("restart_cycle", 32'(cyc), 19);

      // Abort during DONE does not cut the pulse short.
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      check("done_abort_pass", 32'(bus.pass), 1);

      // abort together with start in IDLE: no sweep.
      bus.abort = 1'b1; bus.start = 1'b1;
      step();
      bus.abort = 1'b0; bus.start = 1'b0;
      check("abort_start_busy", 32'(bus.busy), 0);
      step();

      // Reset at cycle 5 of a sweep.
      set_fault(0);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      repeat (4) step();
      reset = 1'b0;
      step();
      reset = 1'b1;
      check("rstmid_busy",  32'(bus.busy), 0);
      check("rstmid_valid", 32'(bus.stim_valid), 0);
      check("rstmid_a",     32'(bus.a), 0);
      step();

      // start while busy is ignored: same length, a single done.
      sweep(0, 0, 1'b1, cyc, got);
      check("spam_cycle", 32'(cyc), 19);
      seen = 1'b0;
      for (int i = 0; i < 25; i++) begin
         step();
         if (bus.done) seen = 1'b1;
      end
      check("spam_single_done", 32'(seen), 0);

      // Randomized sweeps over fault modes, aborts and start spam.
      for (int it = 0; it < 14; it++) begin
         int md, ab;
         md = $urandom_range(0, 4);
         ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, N + L) : 0;
         sweep(md, ab, 1'($urandom_range(0, 1)), cyc, got);
         if (ab == 0) check("rnd_done_seen", 32'(got), 1);
         repeat ($urandom_range(1, 3)) step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
